alu_uart_if: RTL and testbench

//  Sequencer driving the 8-op ALU from a byte stream and returning its result.

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_uart_if_if.sv | 26 ++
 rtl/alu_uart_if.sv | 83 ++++++++
 tb/tb_alu_uart_if.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU/sequencer definitions: widths, opcodes, FSM encoding, error byte.
// The opcode check helper is used when ALU_OPCHK_EN is defined.
package alu_pkg;

   localparam int N_BUS = 8;
   localparam int N_OP  = 6;

   localparam logic [5:0] OP_ADD = 6'b100000;
   localparam logic [5:0] OP_SUB = 6'b100010;
   localparam logic [5:0] OP_AND = 6'b100100;
   localparam logic [5:0] OP_OR  = 6'b100101;
   localparam logic [5:0] OP_XOR = 6'b100110;
   localparam logic [5:0] OP_SRA = 6'b000011;
   localparam logic [5:0] OP_SRL = 6'b000010;
   localparam logic [5:0] OP_NOR = 6'b100111;

   localparam logic [7:0] ERR_BYTE = 8'hEE;

   typedef enum logic [2:0] {
      ST_WAIT_A  = 3'd0,
      ST_WAIT_B  = 3'd1,
      ST_WAIT_OP = 3'd2,
      ST_EXEC    = 3'd3,
      ST_SEND    = 3'd4,
      ST_WAIT_TX = 3'd5
   } state_t;

   // A valid opcode byte has clear upper bits and a known low field.
   function automatic logic is_valid_op(input logic [7:0] op_byte);
      logic valid;
      valid = 1'b0;
      if (op_byte[7:6] != 2'b00) begin
         valid = 1'b0;
      end else begin
         case (op_byte[5:0])
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SRA, OP_SRL, OP_NOR: valid = 1'b1;
            default:                        valid = 1'b0;
         endcase
      end
      return valid;
   endfunction

endpackage

// File: rtl/alu_uart_if_if.sv
// Bus between the byte-stream sequencer and its UART/ALU neighbours.
// slave = sequencer side, master = environment (uart_rx/uart_tx/ALU) side.
interface alu_uart_if_if #(
   parameter int N_BUS = alu_pkg::N_BUS,
   parameter int N_OP  = alu_pkg::N_OP
) ();
   logic             rx_done;
   logic [N_BUS-1:0] rx_data;
   logic [N_BUS-1:0] alu_res;
   logic             tx_done;
   logic [N_BUS-1:0] alu_a;
   logic [N_BUS-1:0] alu_b;
   logic [N_OP-1:0]  alu_op;
   logic             tx_start;
   logic [N_BUS-1:0] tx_data;

   modport slave (
      input  rx_done, rx_data, alu_res, tx_done,
      output alu_a, alu_b, alu_op, tx_start, tx_data
   );

   modport master (
      output rx_done, rx_data, alu_res, tx_done,
      input  alu_a, alu_b, alu_op, tx_start, tx_data
   );
endinterface

// File: rtl/alu_uart_if.sv
// Sequencer: collects A, B, opcode bytes, runs the ALU, sends the result byte.
// Optional opcode check enabled by defining ALU_OPCHK_EN.
module alu_uart_if
   import alu_pkg::*;
(
   input  logic          i_clk,
   input  logic          i_reset,
   alu_uart_if_if.slave  bus
);

   state_t state;

   // Single FSM with all outputs registered; tx_start is a one-cycle pulse in SEND.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state        <= ST_WAIT_A;
         bus.alu_a    <= '0;
         bus.alu_b    <= '0;
         bus.alu_op   <= '0;
         bus.tx_data  <= '0;
         bus.tx_start <= 1'b0;
      end else begin
         bus.tx_start <= 1'b0;
         case (state)
            ST_WAIT_A: begin
               if (bus.rx_done) begin
                  bus.alu_a <= bus.rx_data;
                  state     <= ST_WAIT_B;
               end else begin
                  state     <= ST_WAIT_A;
               end
            end
            ST_WAIT_B: begin
               if (bus.rx_done) begin
                  bus.alu_b <= bus.rx_data;
                  state     <= ST_WAIT_OP;
               end else begin
                  state     <= ST_WAIT_B;
               end
            end
            ST_WAIT_OP: begin
               if (bus.rx_done) begin
`ifdef ALU_OPCHK_EN
                  // Invalid opcode skips EXEC and reports the error byte instead.
                  if (is_valid_op(bus.rx_data)) begin
                     bus.alu_op   <= bus.rx_data[N_OP-1:0];
                     state        <= ST_EXEC;
                  end else begin
                     bus.tx_data  <= ERR_BYTE;
                     bus.tx_start <= 1'b1;
                     state        <= ST_SEND;
                  end
`else
                  bus.alu_op <= bus.rx_data[N_OP-1:0];
                  state      <= ST_EXEC;
`endif
               end else begin
                  state <= ST_WAIT_OP;
               end
            end
            ST_EXEC: begin
               bus.tx_data  <= bus.alu_res;
               bus.tx_start <= 1'b1;
               state        <= ST_SEND;
            end
            ST_SEND: begin
               state <= ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
               if (bus.tx_done) begin
                  state <= ST_WAIT_A;
               end else begin
                  state <= ST_WAIT_TX;
               end
            end
            default: begin
               state <= ST_WAIT_A;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_uart_if.sv
// Directed self-checking bench for alu_uart_if with a behavioural 8-op ALU.
module tb_alu_uart_if;
   import alu_pkg::*;

   logic clk;
   logic reset;
   int   n_assert;
   int   n_fail;

   alu_uart_if_if bus ();

   alu_uart_if dut (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU, combinational from the registered operands.
   always_comb begin
      bus.alu_res = 8'h00;
      case (bus.alu_op)
         OP_ADD:  bus.alu_res = bus.alu_a + bus.alu_b;
         OP_SUB:  bus.alu_res = bus.alu_a - bus.alu_b;
         OP_AND:  bus.alu_res = bus.alu_a & bus.alu_b;
         OP_OR:   bus.alu_res = bus.alu_a | bus.alu_b;
         OP_XOR:  bus.alu_res = bus.alu_a ^ bus.alu_b;
         OP_SRA:  bus.alu_res = 8'($signed(bus.alu_a) >>> bus.alu_b);
         OP_SRL:  bus.alu_res = bus.alu_a >> bus.alu_b;
         OP_NOR:  bus.alu_res = ~(bus.alu_a | bus.alu_b);
         default: bus.alu_res = 8'h00;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus.rx_done = 1'b1;
      bus.rx_data = b;
      @(negedge clk);
      bus.rx_done = 1'b0;
   endtask

   task automatic pulse_tx_done();
      bus.tx_done = 1'b1;
      @(negedge clk);
      bus.tx_done = 1'b0;
   endtask

   // Full valid sequence; returns at the negedge of the first WAIT_TX cycle.
   task automatic run_seq(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] op, input logic [7:0] exp);
      send_byte(a);
      send_byte(b);
      send_byte(op);
      check({tag, "_exec_state"}, 32'(dut.state), 32'(ST_EXEC));
      check({tag, "_exec_start"}, 32'(bus.tx_start), 32'd0);
      check({tag, "_exec_op"},    32'(bus.alu_op), 32'(op[5:0]));
      @(negedge clk);
      check({tag, "_send_start"}, 32'(bus.tx_start), 32'd1);
      check({tag, "_send_data"},  32'(bus.tx_data), 32'(exp));
      @(negedge clk);
      check({tag, "_wtx_start"},  32'(bus.tx_start), 32'd0);
      check({tag, "_wtx_state"},  32'(dut.state), 32'(ST_WAIT_TX));
   endtask

   initial begin
      int starts;
      n_assert    = 0;
      n_fail      = 0;
      reset       = 1'b1;
      bus.rx_done = 1'b0;
      bus.rx_data = 8'h00;
      bus.tx_done = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_a",     32'(bus.alu_a), 32'd0);
      check("rst_b",     32'(bus.alu_b), 32'd0);
      check("rst_op",    32'(bus.alu_op), 32'd0);
      check("rst_txd",   32'(bus.tx_data), 32'd0);
      check("rst_start", 32'(bus.tx_start), 32'd0);
      check("rst_state", 32'(dut.state), 32'(ST_WAIT_A));
      reset = 1'b0;

      // tx_done outside WAIT_TX is ignored
      pulse_tx_done();
      check("idle_txdone", 32'(dut.state), 32'(ST_WAIT_A));

      run_seq("t1_add", 8'h05, 8'h03, 8'h20, 8'h08);
      pulse_tx_done();
      check("t1_back", 32'(dut.state), 32'(ST_WAIT_A));

      run_seq("t2_sub", 8'h03, 8'h05, 8'h22, 8'hFE);
      pulse_tx_done();
      run_seq("t2_sra", 8'h80, 8'h02, 8'h03, 8'hE0);
      pulse_tx_done();

      run_seq("t3_srl", 8'h80, 8'h02, 8'h02, 8'h20);
      starts = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.tx_start === 1'b1) starts++;
      end
      check("t3_no_start", 32'(starts), 32'd0);
      check("t3_hold",     32'(dut.state), 32'(ST_WAIT_TX));

      send_byte(8'hAA);
      check("t4_drop_state", 32'(dut.state), 32'(ST_WAIT_TX));
      check("t4_drop_a",     32'(bus.alu_a), 32'h80);
      // rx byte coinciding with tx_done is also dropped
      bus.rx_done = 1'b1;
      bus.rx_data = 8'h55;
      pulse_tx_done();
      bus.rx_done = 1'b0;
      check("t4_coinc_state", 32'(dut.state), 32'(ST_WAIT_A));
      check("t4_coinc_a",     32'(bus.alu_a), 32'h80);
      run_seq("t4_and", 8'h01, 8'h01, 8'h24, 8'h01);
      check("t4_a", 32'(bus.alu_a), 32'h01);
      pulse_tx_done();

      send_byte(8'h11);
      check("t5_pre_state", 32'(dut.state), 32'(ST_WAIT_B));
      check("t5_pre_a",     32'(bus.alu_a), 32'h11);
      reset = 1'b1;
      @(negedge clk);
      check("t5_rst_a",     32'(bus.alu_a), 32'd0);
      check("t5_rst_b",     32'(bus.alu_b), 32'd0);
      check("t5_rst_op",    32'(bus.alu_op), 32'd0);
      check("t5_rst_txd",   32'(bus.tx_data), 32'd0);
      check("t5_rst_start", 32'(bus.tx_start), 32'd0);
      check("t5_rst_state", 32'(dut.state), 32'(ST_WAIT_A));
      reset = 1'b0;
      run_seq("t5_or", 8'h0F, 8'hF0, 8'h25, 8'hFF);
      pulse_tx_done();

      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h3F);
`ifdef ALU_OPCHK_EN
      check("t6_state", 32'(dut.state), 32'(ST_SEND));
      check("t6_start", 32'(bus.tx_start), 32'd1);
      check("t6_data",  32'(bus.tx_data), 32'hEE);
      check("t6_op",    32'(bus.alu_op), 32'h25);
`else
      check("t6_state", 32'(dut.state), 32'(ST_EXEC));
      check("t6_op",    32'(bus.alu_op), 32'h3F);
      @(negedge clk);
      check("t6_start", 32'(bus.tx_start), 32'd1);
      check("t6_data",  32'(bus.tx_data), 32'h00);
`endif
      @(negedge clk);
      check("t6_wtx", 32'(dut.state), 32'(ST_WAIT_TX));
      pulse_tx_done();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
